quick_add_round_ctrl: RTL
=========================

Name: quick_add_round_ctrl

Overview:
- Round controller for the Quick Add game.
- Sits directly upstream of the 16-bit up/down loadable counter that holds the round time.
- Generates that counter's load, preset value, up and down controls, and consumes its count and terminal-count flags.
- Tracks score and timeout; drives flash and status signals to the display stage.

Parameters:
START_TIME, 16'h0020, value loaded into the time counter at round start (32 ticks)
BONUS, 4, number of up-counts added to the time counter per correct answer (1..15)
MAX_SCORE, 15, score at which the game ends in WIN (1..255)
FLASH_TICKS, 4, tick_in pulses per flash_out toggle in OVER/WIN (1..15)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
start_in  input  1  one-cycle start pulse (debounced button)
tick_in  input  1  one-cycle time-base pulse
ans_valid_in  input  1  one-cycle pulse: player submitted an answer
ans_correct_in  input  1  qualifies ans_valid_in; 1 = answer correct
cnt_q_in  input  16  current time-counter value
cnt_utc_in  input  1  time counter at 16'hFFFF
cnt_dtc_in  input  1  time counter at 16'h0000
cnt_din_out  output  16  counter preset value, always START_TIME
cnt_ld_out  output  1  counter load strobe
cnt_up_out  output  1  counter count-up enable
cnt_dw_out  output  1  counter count-down enable
score_out  output  8  correct answers this game
active_out  output  1  1 while in RUN or BONUS
timeout_out  output  1  one-cycle pulse on entry to OVER
win_out  output  1  level, 1 in WIN
flash_out  output  1  display blink control
state_out  output  3  current state encoding, for debug LEDs

Behaviour:
- Clock and reset: one clock clk_in. Reset rst_in is synchronous and active-high. Reset (including mid-round) forces IDLE, score 0, pending_tick 0, bonus count 0, flash_out 0. All outputs are 0 during reset except cnt_din_out, which is always START_TIME.
- Counter controls: cnt_ld_out, cnt_up_out and cnt_dw_out are decoded combinationally from state and inputs. The counter registers them, so the count changes one cycle after assertion. At most one of the three is asserted in any cycle.
- IDLE: controls 0. start_in moves to LOAD.
- LOAD (one cycle): cnt_ld_out=1; score and pending_tick cleared; then RUN.
- RUN:
  - cnt_dw_out = (tick_in | pending_tick) & ~cnt_dtc_in. The counter never decrements below 0. pending_tick clears when consumed.
  - Priority order each cycle:
    1. cnt_dtc_in=1: go to OVER; any answer in that cycle is ignored.
    2. ans_valid_in & ans_correct_in: score+1 (saturates at 255). If the new score equals MAX_SCORE, go to WIN; otherwise go to BONUS with the bonus counter = BONUS.
    3. ans_valid_in & ~ans_correct_in: no score or count change; stay in RUN.
  - A tick arriving in the same cycle as a correct answer still decrements in that cycle.
  - start_in is ignored.
- BONUS:
  - cnt_up_out = ~cnt_utc_in; the count saturates at FFFF.
  - The bonus counter decrements every cycle; return to RUN when it reaches 1, giving BONUS cycles total.
  - A tick_in during BONUS sets pending_tick; multiple ticks collapse to one.
  - Answers are ignored.
- OVER: timeout_out pulses in the entry cycle only. flash_out toggles every FLASH_TICKS tick_in pulses, starting from 0. start_in moves to LOAD.
- WIN: win_out=1; flash_out toggles as in OVER; start_in moves to LOAD.
- Display hold: score_out holds its value in OVER and WIN and clears only in LOAD. flash_out is 0 outside OVER and WIN.
- State encoding (3 bits): IDLE=0, LOAD=1, RUN=2, BONUS=3, OVER=4, WIN=5. Unused codes go to IDLE next cycle.
- Visibility latency: because cnt_dtc_in comes from the registered counter, zero is seen one cycle after the final decrement. OVER is entered on the cycle after that.

Decomposition:
- Package quick_add_pkg holds:
  - the state typedef and encodings;
  - TIME_W=16 and SCORE_W=8;
  - default START_TIME, BONUS and MAX_SCORE.
- One sub-module, flash_blinker: a tick-counting toggle with enable and synchronous clear, reused by the display stage.

Test Plan:
- Reset then start_in → cnt_ld_out=1 for exactly 1 cycle with cnt_din_out=16'h0020, then RUN; score_out=0, active_out=1.
- Countdown to timeout: 32 tick_in pulses with no answers → cnt_dw_out asserted 32 times, count reaches 0. OVER is entered the cycle after cnt_dtc_in=1, timeout_out pulses once, and no further cnt_dw_out.
- Correct answer: count=16'h0010 → BONUS, cnt_up_out high for 4 cycles, count=16'h0014, score_out=1. A tick_in during BONUS yields exactly one cnt_dw_out on the first RUN cycle, giving 16'h0013.
- Wrong answer at count 5 → no up/down/load pulses, score unchanged, still RUN. A correct answer together with tick_in in one cycle → dw that cycle, then BONUS.
- Win: 15 correct answers → win_out=1, score_out=15. With FLASH_TICKS=4, flash_out toggles after every 4th tick. start_in → LOAD, score_out=0.
- Boundaries:
  - rst_in asserted mid-BONUS → next cycle IDLE, all controls 0, score 0.
  - cnt_utc_in=1 in BONUS → cnt_up_out stays 0.
  - cnt_dtc_in=1 together with a correct answer → OVER, score unchanged.

Source files
------------

// File: rtl/quick_add_pkg.sv
// ============================================================================
// Module   : quick_add_pkg
// Purpose  : Shared types, widths and defaults for the Quick Add round logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package quick_add_pkg;

    localparam int TIME_W  = 16;
    localparam int SCORE_W = 8;
    localparam int BONUS_W = 4;
    localparam int FLASH_W = 4;

    localparam logic [TIME_W-1:0] DEF_START_TIME  = 16'h0020;
    localparam int                DEF_BONUS       = 4;
    localparam int                DEF_MAX_SCORE   = 15;
    localparam int                DEF_FLASH_TICKS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_BONUS = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/quick_add_round_ctrl_flash_blinker.sv
// ============================================================================
// Module   : flash_blinker
// Purpose  : Toggles its output once every FLASH_TICKS enabled tick pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_blinker
    import quick_add_pkg::*;
#(
    parameter int FLASH_TICKS = DEF_FLASH_TICKS
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    input  logic clr_in,
    input  logic tick_in,
    output logic flash_out
);

    logic [FLASH_W-1:0] cnt_q, cnt_d;
    logic               flash_q, flash_d;

    always_comb begin
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (clr_in) begin
            cnt_d   = '0;
            flash_d = 1'b0;
        end else if (en_in && tick_in) begin
            if (cnt_q >= FLASH_W'(FLASH_TICKS - 1)) begin
                cnt_d   = '0;
                flash_d = ~flash_q;
            end else begin
                cnt_d = cnt_q + FLASH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flash_out = flash_q;

endmodule

`default_nettype wire

// File: rtl/quick_add_round_ctrl.sv
// ============================================================================
// Module   : quick_add_round_ctrl
// Purpose  : Round controller driving the Quick Add time counter and display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quick_add_round_ctrl
    import quick_add_pkg::*;
#(
    parameter logic [TIME_W-1:0] START_TIME  = DEF_START_TIME,
    parameter int                BONUS       = DEF_BONUS,
    parameter int                MAX_SCORE   = DEF_MAX_SCORE,
    parameter int                FLASH_TICKS = DEF_FLASH_TICKS
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                tick_in,
    input  logic                ans_valid_in,
    input  logic                ans_correct_in,
    input  logic [TIME_W-1:0]   cnt_q_in,
    input  logic                cnt_utc_in,
    input  logic                cnt_dtc_in,
    output logic [TIME_W-1:0]   cnt_din_out,
    output logic                cnt_ld_out,
    output logic                cnt_up_out,
    output logic                cnt_dw_out,
    output logic [SCORE_W-1:0]  score_out,
    output logic                active_out,
    output logic                timeout_out,
    output logic                win_out,
    output logic                flash_out,
    output logic [2:0]          state_out
);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [BONUS_W-1:0]   bonus_q, bonus_d;
    logic                 pending_q, pending_d;
    logic                 timeout_q, timeout_d;
    logic                 ld_c, up_c, dw_c;
    logic                 at_zero, at_full;
    logic                 in_disp;
    logic                 flash_raw;

    // The count value backs up the flags so a glitched flag cannot wrap the timer.
    assign at_zero = cnt_dtc_in | (cnt_q_in == '0);
    assign at_full = cnt_utc_in | (cnt_q_in == '1);

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        bonus_d   = bonus_q;
        pending_d = pending_q;
        ld_c      = 1'b0;
        up_c      = 1'b0;
        dw_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ld_c      = 1'b1;
                score_d   = '0;
                pending_d = 1'b0;
                bonus_d   = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                dw_c = (tick_in | pending_q) & ~at_zero;
                if (dw_c) pending_d = 1'b0;
                if (at_zero) begin
                    state_d = ST_OVER;
                end else if (ans_valid_in && ans_correct_in) begin
                    score_d = sat_inc(score_q);
                    if (score_d == SCORE_W'(MAX_SCORE)) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_BONUS;
                        bonus_d = BONUS_W'(BONUS);
                    end
                end
            end
            ST_BONUS: begin
                up_c    = ~at_full;
                bonus_d = bonus_q - BONUS_W'(1);
                if (tick_in) pending_d = 1'b1;
                if (bonus_q <= BONUS_W'(1)) state_d = ST_RUN;
            end
            ST_OVER, ST_WIN: begin
                if (start_in) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        timeout_d = (state_d == ST_OVER) && (state_q != ST_OVER);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            bonus_q   <= '0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            bonus_q   <= bonus_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
        end
    end

    assign in_disp = (state_q == ST_OVER) || (state_q == ST_WIN);

    flash_blinker #(
        .FLASH_TICKS (FLASH_TICKS)
    ) u_flash (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (in_disp),
        .clr_in    (~in_disp),
        .tick_in   (tick_in),
        .flash_out (flash_raw)
    );

    // Everything but the preset value is forced low while reset is held.
    assign cnt_din_out = START_TIME;
    assign cnt_ld_out  = ld_c & ~rst_in;
    assign cnt_up_out  = up_c & ~rst_in;
    assign cnt_dw_out  = dw_c & ~rst_in;
    assign score_out   = rst_in ? '0 : score_q;
    assign active_out  = ~rst_in & ((state_q == ST_RUN) || (state_q == ST_BONUS));
    assign timeout_out = timeout_q & ~rst_in;
    assign win_out     = ~rst_in & (state_q == ST_WIN);
    assign flash_out   = flash_raw & in_disp & ~rst_in;
    assign state_out   = rst_in ? 3'd0 : state_q;

endmodule

`default_nettype wire
